uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_pkg.sv | 21 ++
 rtl/edge_bit_counter.sv | 27 ++
 rtl/uart_rx_fsm.sv | 111 +++++++++++
 tb/tb_uart_rx_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;
    localparam int         DATA_WIDTH_DEFAULT = 8;

    // Anything other than the two supported ratios falls back to 8.
    function automatic logic [4:0] legal_prescale(input logic [4:0] p);
        return (p == PRESCALE_16) ? PRESCALE_16 : PRESCALE_8;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample tick and frame-bit counters; cleared whenever enable is low.
// wrap marks the last tick of the current bit.
module edge_bit_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] p,
    output logic       wrap,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt
);

    assign wrap = (edge_cnt == p - 5'd1);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frames start/data/parity/stop bits and strobes the checkers.
// All strobes are registered and land on the last oversample tick of their bit.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX_IN,
    input  logic [4:0] Prescale,
    input  logic       PAR_EN,
    input  logic       sampled_bit,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       data_samp_en,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       busy
);

    state_e     state;
    state_e     state_next;
    logic [4:0] p_q;
    logic       par_en_q;
    logic       par_flag;
    logic       wrap;
    logic       count_en;
    logic       pre_end;
    logic       unused_ok;

    // The sampled data path lives in the deserializer, not here.
    assign unused_ok = sampled_bit;

    // Counters run only while staying inside a frame, so they read 0 in IDLE
    // and on the first START tick.
    assign count_en = (state != IDLE) && (state_next != IDLE);

    edge_bit_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .enable   (count_en),
        .p        (p_q),
        .wrap     (wrap),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!RX_IN) state_next = START;
            START:   if (wrap) state_next = strt_glitch ? IDLE : DATA;
            DATA:    if (wrap && bit_cnt == 4'(DATA_WIDTH))
                         state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (wrap) state_next = STOP;
            STOP:    if (wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registering one tick early puts each strobe on the bit-end cycle.
    assign pre_end = (edge_cnt == p_q - 5'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q          <= PRESCALE_8;
            par_en_q     <= 1'b0;
            par_flag     <= 1'b0;
            strt_chk_en  <= 1'b0;
            deser_en     <= 1'b0;
            par_chk_en   <= 1'b0;
            stp_chk_en   <= 1'b0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            data_samp_en <= 1'b0;
        end else begin
            if (state == IDLE && !RX_IN) begin
                p_q      <= legal_prescale(Prescale);
                par_en_q <= PAR_EN;
            end
            if (state == IDLE) begin
                par_flag <= 1'b0;
            end else if (state == PARITY && wrap && par_err) begin
                par_flag <= 1'b1;
            end
            strt_chk_en  <= (state == START)  && pre_end;
            deser_en     <= (state == DATA)   && pre_end;
            par_chk_en   <= (state == PARITY) && pre_end;
            stp_chk_en   <= (state == STOP)   && pre_end;
            data_valid   <= (state == STOP) && wrap && !stp_err && !par_flag;
            busy         <= (state_next != IDLE);
            data_samp_en <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized frame bench for uart_rx_fsm with a queue scoreboard on strobe/valid timing.
module tb_uart_rx_fsm;

    localparam int DW = 8;

    logic       clk;
    logic       reset;
    logic       RX_IN;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       sampled_bit;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       data_samp_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       busy;

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .sampled_bit  (sampled_bit),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .deser_en     (deser_en),
        .data_valid   (data_valid),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int q_valid[$];
    int q_strt[$];
    int q_stp[$];
    int deser_seen = 0;
    int par_seen   = 0;
    int stp_seen   = 0;
    int last_valid = -1;
    int prev_valid = -1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got pulse at cycle %0d expected none", name, cyc);
    endtask

    // Monitor: every observed pulse must match the oldest predicted cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                if (q_valid.size() == 0) unexpected("data_valid");
                else check("data_valid_cycle", cyc, q_valid.pop_front());
                prev_valid = last_valid;
                last_valid = cyc;
            end
            if (strt_chk_en) begin
                if (q_strt.size() == 0) unexpected("strt_chk_en");
                else check("strt_chk_cycle", cyc, q_strt.pop_front());
            end
            if (stp_chk_en) begin
                stp_seen++;
                if (q_stp.size() == 0) unexpected("stp_chk_en");
                else check("stp_chk_cycle", cyc, q_stp.pop_front());
            end
            if (deser_en) deser_seen++;
            if (par_chk_en) par_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_samp_en"}, data_samp_en, 0);
        check({tag, "_edge_cnt"}, edge_cnt, 0);
        check({tag, "_bit_cnt"}, bit_cnt, 0);
        check({tag, "_strobes"}, {strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}, 0);
    endtask

    // Frame of nbits bits starting at cycle t0 (the IDLE cycle seeing RX_IN low):
    // bit k occupies cycles t0+1+k*P .. t0+(k+1)*P, IDLE again at t0+nbits*P+1.
    task automatic run_frame(input int pre, input bit pen, input bit glitch,
                             input bit perr, input bit serr, input logic [DW-1:0] dat);
        int   p, nbits, t0, d0, p0, s0;
        logic lv [0:15];
        p     = (pre == 16) ? 16 : 8;
        nbits = glitch ? 1 : (2 + DW + (pen ? 1 : 0));
        t0    = cyc;
        lv[0] = 1'b0;
        for (int k = 0; k < DW; k++) lv[k+1] = dat[k];
        lv[DW+1] = pen ? ^dat : 1'b1;
        for (int k = DW + 2; k < 16; k++) lv[k] = 1'b1;

        q_strt.push_back(t0 + p);
        if (!glitch) q_stp.push_back(t0 + nbits * p);
        if (!glitch && !serr && !(pen && perr)) q_valid.push_back(t0 + nbits * p + 1);
        d0 = deser_seen;
        p0 = par_seen;
        s0 = stp_seen;

        Prescale    = 5'(pre);
        PAR_EN      = pen;
        strt_glitch = glitch;
        par_err     = perr;
        stp_err     = serr;
        for (int c = 0; c <= nbits * p; c++) begin
            if (c == 0) RX_IN = 1'b0;
            else if (glitch) RX_IN = (c < 4) ? 1'b0 : 1'b1;
            else RX_IN = lv[(c - 1) / p];
            sampled_bit = RX_IN;
            if (c == 1) begin
                check("start_edge_cnt", edge_cnt, 0);
                check("start_bit_cnt", bit_cnt, 0);
                check("start_busy", busy, 1);
                Prescale = 5'($urandom_range(0, 31));
                PAR_EN   = 1'($urandom);
            end
            if (c == p) check("start_end_edge_cnt", edge_cnt, p - 1);
            tick();
        end
        check("frame_end_busy", busy, 0);
        check("frame_end_bit_cnt", bit_cnt, 0);
        check("frame_deser_count", deser_seen - d0, glitch ? 0 : DW);
        check("frame_par_count", par_seen - p0, (pen && !glitch) ? 1 : 0);
        check("frame_stp_count", stp_seen - s0, glitch ? 0 : 1);
    endtask

    // Start a P=8 no-parity frame and pull reset during data bit 4.
    task automatic abort_frame();
        int t0, d0;
        t0 = cyc;
        d0 = deser_seen;
        q_strt.push_back(t0 + 8);
        Prescale    = 5'd8;
        PAR_EN      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        for (int c = 0; c <= 4 * 8 + 2; c++) begin
            RX_IN = (c <= 8) ? 1'b0 : 1'($urandom);
            tick();
        end
        check("abort_bit_cnt_before", bit_cnt, 4);
        reset = 1'b1;
        RX_IN = 1'b1;
        tick();
        check_all_zero("abort_reset");
        check("abort_deser_count", deser_seen - d0, 3);
        reset = 1'b0;
        tick();
        check("abort_after_busy", busy, 0);
    endtask

    initial begin
        reset       = 1'b1;
        RX_IN       = 1'b1;
        Prescale    = 5'd8;
        PAR_EN      = 1'b0;
        sampled_bit = 1'b1;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);
        check("idle_busy", busy, 0);

        run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        idle(1);
        run_frame(16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(1);
        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        idle(2);
        run_frame(8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);
        run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0);
        idle(2);
        abort_frame();
        idle(1);
        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96);

        run_frame(12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        run_frame(12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        tick();
        check("back_to_back_gap", last_valid - prev_valid, (2 + DW + 1) * 8 + 1);

        for (int i = 0; i < 24; i++) begin
            int pre;
            case ($urandom_range(0, 3))
                0:       pre = 8;
                1:       pre = 16;
                2:       pre = 12;
                default: pre = $urandom_range(0, 31);
            endcase
            run_frame(pre, 1'($urandom), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      8'($urandom));
            idle($urandom_range(0, 3));
        end

        idle(4);
        check("pending_valid", q_valid.size(), 0);
        check("pending_strt", q_strt.size(), 0);
        check("pending_stp", q_stp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
